// File: rtl/i2c_pwm_regs.sv
// I2C target register file holding one 8-bit duty value per PWM channel.
module i2c_pwm_regs #(
    parameter int unsigned CHANNELS = 1,
    parameter logic [6:0]  I2C_ADDR = 7'h28
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     scl_in,
    input  logic                     sda_in,
    output logic                     sda_oe,
    output logic [CHANNELS-1:0][7:0] pwm_value
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_REG       = 4'd3,
        S_REG_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_scl_s1, r_scl_s2, r_scl_d;
    logic                      r_sda_s1, r_sda_s2, r_sda_d;
    logic [CNT_W-1:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]                r_shift, w_shift_nxt;
    logic [7:0]                r_ptr, w_ptr_nxt;
    logic                      r_sda_oe, w_sda_oe_nxt;
    logic                      w_wr_en;
    logic [CHANNELS-1:0][7:0]  r_pwm;
    logic                      w_scl_rise, w_scl_fall, w_start, w_stop;
    logic                      w_last;
    logic [7:0]                w_byte, w_ptr_inc, w_rd_cur, w_rd_next;

    assign sda_oe    = r_sda_oe;
    assign pwm_value = r_pwm;

    // Synchronisers plus history flop; idle-high reset avoids false events
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_in, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_in, r_sda_s1, r_sda_s2};
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_last     = (r_bit_cnt == CNT_W'(7));
    assign w_ptr_inc  = r_ptr + 8'd1;

    // Read data at ptr and ptr+1; out-of-range entries read as zero
    always_comb begin
        w_rd_cur  = 8'h00;
        w_rd_next = 8'h00;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (r_ptr == 8'(i))     w_rd_cur  = r_pwm[i];
            if (w_ptr_inc == 8'(i)) w_rd_next = r_pwm[i];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next-state logic; STOP and START override every state
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
        end else begin
            case (r_state)
                S_IDLE:      w_state_nxt = S_IDLE;
                S_ADDR:      if (w_scl_rise && w_last)
                                 w_state_nxt = (w_byte[7:1] == I2C_ADDR) ? S_ADDR_ACK : S_IDLE;
                S_ADDR_ACK:  if (w_scl_fall && r_bit_cnt != '0)
                                 w_state_nxt = r_shift[0] ? S_RDATA : S_REG;
                S_REG:       if (w_scl_rise && w_last) w_state_nxt = S_REG_ACK;
                S_REG_ACK:   if (w_scl_fall && r_bit_cnt != '0) w_state_nxt = S_WDATA;
                S_WDATA:     if (w_scl_rise && w_last) w_state_nxt = S_WDATA_ACK;
                S_WDATA_ACK: if (w_scl_fall && r_bit_cnt != '0) w_state_nxt = S_WDATA;
                S_RDATA:     if (w_scl_fall && r_bit_cnt == CNT_W'(8)) w_state_nxt = S_RDATA_ACK;
                S_RDATA_ACK: if (w_scl_rise) w_state_nxt = r_sda_s2 ? S_IDLE : S_RDATA;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM output logic: next values for counter, shifter, pointer, SDA drive
    always_comb begin
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_oe_nxt  = r_sda_oe;
        w_wr_en       = 1'b0;
        if (w_stop || w_start) begin
            w_bit_cnt_nxt = '0;
            w_sda_oe_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_REG, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = w_last ? '0 : r_bit_cnt + CNT_W'(1);
                        if (w_last && r_state == S_REG) w_ptr_nxt = w_byte;
                        if (w_last && r_state == S_WDATA) begin
                            w_wr_en   = 1'b1;
                            w_ptr_nxt = w_ptr_inc;
                        end
                    end
                end
                S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = CNT_W'(1);
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == '0) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = '0;
                            if (r_state == S_ADDR_ACK && r_shift[0]) begin
                                w_shift_nxt  = w_rd_cur;
                                w_sda_oe_nxt = ~w_rd_cur[7];
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == CNT_W'(8)) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = '0;
                        end else if (r_bit_cnt == '0) begin
                            w_sda_oe_nxt = ~r_shift[7];
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_ptr_nxt     = w_ptr_inc;
                        w_bit_cnt_nxt = '0;
                        if (!r_sda_s2) w_shift_nxt = w_rd_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers and duty array; only the addressed entry is written
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_bit_cnt <= '0;
            r_shift   <= 8'h00;
            r_ptr     <= 8'h00;
            r_sda_oe  <= 1'b0;
            r_pwm     <= '0;
        end else begin
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (w_wr_en && r_ptr == 8'(i)) r_pwm[i] <= w_byte;
            end
        end
    end

endmodule

// File: tb/tb_i2c_pwm_regs.sv
// Directed bench for i2c_pwm_regs: 4 channels at address 0x28.
module tb_i2c_pwm_regs;

    localparam int unsigned CH = 4;
    localparam int unsigned Q  = 100;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              scl;
    logic              sda_m;
    logic              sda_oe;
    logic [CH-1:0][7:0] pwm_value;
    logic              sda_line;

    int n_chk  = 0;
    int n_fail = 0;
    int oe_cycles = 0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_pwm_regs #(.CHANNELS(CH), .I2C_ADDR(7'h28)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .pwm_value (pwm_value)
    );

    // 100 MHz-equivalent clock, SCL period is 40 clocks
    always #5 clk = ~clk;

    // Count cycles where the target pulls SDA
    always @(posedge clk) if (sda_oe) oe_cycles <= oe_cycles + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; #Q;
        scl   = 1'b1; #(2*Q);
        scl   = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #Q;
        b     = sda_line; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~master_ack);
    endtask

    // Watchdog so the bench always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        int         snap;

        n_rst = 1'b0; scl = 1'b1; sda_m = 1'b1;
        #23;
        check_eq("rst_sda_oe", 32'(sda_oe), 32'h0);
        check_eq("rst_pwm",    32'(pwm_value), 32'h0);
        check_eq("rst_ptr",    32'(dut.r_ptr), 32'h0);
        check_eq("rst_state",  32'(dut.r_state), 32'h0);
        n_rst = 1'b1;
        #50;

        // Burst write 0xAA, 0xBB starting at register 1
        i2c_start();
        write_byte(8'h50, ack); check_eq("bw_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h01, ack); check_eq("bw_reg_ack",  32'(ack), 32'h1);
        write_byte(8'hAA, ack); check_eq("bw_d0_ack",   32'(ack), 32'h1);
        write_byte(8'hBB, ack); check_eq("bw_d1_ack",   32'(ack), 32'h1);
        i2c_stop();
        #50;
        check_eq("bw_pwm",   32'(pwm_value), 32'h00BBAA00);
        check_eq("bw_ptr",   32'(dut.r_ptr), 32'h3);
        check_eq("bw_state", 32'(dut.r_state), 32'h0);

        // Wrong address: no ACK ever, nothing written
        snap = oe_cycles;
        i2c_start();
        write_byte(8'h52, ack); check_eq("wa_addr_nack", 32'(ack), 32'h0);
        write_byte(8'h00, ack); check_eq("wa_reg_nack",  32'(ack), 32'h0);
        write_byte(8'h11, ack); check_eq("wa_d_nack",    32'(ack), 32'h0);
        i2c_stop();
        #50;
        check_eq("wa_oe_cycles", 32'(oe_cycles - snap), 32'h0);
        check_eq("wa_pwm",       32'(pwm_value), 32'h00BBAA00);

        // Repeated-start read of registers 2 and 3
        i2c_start();
        write_byte(8'h50, ack); check_eq("rd_addr_ack",  32'(ack), 32'h1);
        write_byte(8'h02, ack); check_eq("rd_reg_ack",   32'(ack), 32'h1);
        i2c_start();
        write_byte(8'h51, ack); check_eq("rd_raddr_ack", 32'(ack), 32'h1);
        read_byte(1'b1, d);     check_eq("rd_byte0",     32'(d), 32'hBB);
        read_byte(1'b0, d);     check_eq("rd_byte1",     32'(d), 32'h00);
        i2c_stop();
        #50;
        check_eq("rd_ptr",   32'(dut.r_ptr), 32'h4);
        check_eq("rd_pwm",   32'(pwm_value), 32'h00BBAA00);

        // Out-of-range write discarded, pointer wraps to register 0
        i2c_start();
        write_byte(8'h50, ack); check_eq("wr_addr_ack", 32'(ack), 32'h1);
        write_byte(8'hFF, ack); check_eq("wr_reg_ack",  32'(ack), 32'h1);
        write_byte(8'h33, ack); check_eq("wr_d0_ack",   32'(ack), 32'h1);
        write_byte(8'h44, ack); check_eq("wr_d1_ack",   32'(ack), 32'h1);
        i2c_stop();
        #50;
        check_eq("wr_pwm", 32'(pwm_value), 32'h00BBAA44);
        check_eq("wr_ptr", 32'(dut.r_ptr), 32'h1);

        // STOP after 4 data bits aborts the byte
        i2c_start();
        write_byte(8'h50, ack); check_eq("ab_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h03, ack); check_eq("ab_reg_ack",  32'(ack), 32'h1);
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        i2c_stop();
        #50;
        check_eq("ab_state",  32'(dut.r_state), 32'h0);
        check_eq("ab_pwm",    32'(pwm_value), 32'h00BBAA44);
        check_eq("ab_sda_oe", 32'(sda_oe), 32'h0);

        // Asynchronous reset in the middle of a data byte
        i2c_start();
        write_byte(8'h50, ack);
        write_byte(8'h00, ack);
        put_bit(1'b0); put_bit(1'b1); put_bit(1'b1); put_bit(1'b1);
        check_eq("mr_state_pre", 32'(dut.r_state), 32'h5);
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check_eq("mr_sda_oe", 32'(sda_oe), 32'h0);
        check_eq("mr_pwm",    32'(pwm_value), 32'h0);
        #20 n_rst = 1'b1;
        #50;

        // Normal transfer after reset: write then read back register 0
        i2c_start();
        write_byte(8'h50, ack); check_eq("pr_addr_ack", 32'(ack), 32'h1);
        write_byte(8'h00, ack); check_eq("pr_reg_ack",  32'(ack), 32'h1);
        write_byte(8'h5A, ack); check_eq("pr_d_ack",    32'(ack), 32'h1);
        i2c_stop();
        #50;
        check_eq("pr_pwm", 32'(pwm_value), 32'h0000005A);
        i2c_start();
        write_byte(8'h50, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'h51, ack); check_eq("pr_raddr_ack", 32'(ack), 32'h1);
        read_byte(1'b0, d);     check_eq("pr_rbyte",     32'(d), 32'h5A);
        i2c_stop();
        #50;
        check_eq("pr_ptr",    32'(dut.r_ptr), 32'h1);
        check_eq("pr_sda_oe", 32'(sda_oe), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
